// File: rtl/fir_mac_sequencer.sv
// Per-sample control sequencer for the FIR MAC slice: coefficient reads, tap select, add/acc enables, done.
// Optional macro SAMPLE_QUEUE_EN adds a one-deep pending-strobe flag for back-to-back samples.
module fir_mac_sequencer #(
  parameter int TAPS       = 5,
  parameter int ADDR_WIDTH = 4,
  parameter int BASE_ADDR  = 0
) (
  input  logic                  iClk_12M,
  input  logic                  iRsn,
  input  logic                  iEnSample,
  input  logic                  iClrOverrun,
  output logic                  oCoeffRdEn,
  output logic [ADDR_WIDTH-1:0] oCoeffAddr,
  output logic [3:0]            oEnMul,
  output logic                  oEnAdd,
  output logic                  oEnAcc,
  output logic                  oBusy,
  output logic                  oDone,
  output logic                  oOverrun
);

  typedef enum logic [1:0] {S_IDLE, S_RD, S_MAC, S_DONE} state_t;

  localparam logic [3:0]            LP_TAPS = 4'(TAPS);
  localparam logic [ADDR_WIDTH-1:0] LP_BASE = ADDR_WIDTH'(BASE_ADDR);

  state_t     r_state;
  logic [3:0] r_tap;

  logic       w_busy;
  logic       w_drop;
  logic       w_restart;
  logic       w_more;
  logic [3:0] w_next_tap;

  assign w_busy     = (r_state != S_IDLE);
  assign w_next_tap = r_tap + 4'd1;
  assign w_more     = (w_next_tap < LP_TAPS);

`ifdef SAMPLE_QUEUE_EN
  logic r_pending;

  assign w_drop    = iEnSample & w_busy & r_pending;
  assign w_restart = r_pending | iEnSample;

  // DONE always consumes the flag: either it launches the next sequence or the strobe went straight to RD.
  always_ff @(posedge iClk_12M or negedge iRsn) begin
    if (!iRsn) begin
      r_pending <= 1'b0;
    end else if (r_state == S_DONE) begin
      r_pending <= 1'b0;
    end else if (iEnSample && w_busy) begin
      r_pending <= 1'b1;
    end
  end
`else
  assign w_drop    = iEnSample & w_busy;
  assign w_restart = 1'b0;
`endif

  always_ff @(posedge iClk_12M or negedge iRsn) begin
    if (!iRsn) begin
      r_state    <= S_IDLE;
      r_tap      <= 4'd0;
      oCoeffRdEn <= 1'b0;
      oCoeffAddr <= '0;
      oEnMul     <= 4'd0;
      oEnAdd     <= 1'b0;
      oEnAcc     <= 1'b0;
      oBusy      <= 1'b0;
      oDone      <= 1'b0;
      oOverrun   <= 1'b0;
    end else begin
      oCoeffRdEn <= 1'b0;
      oCoeffAddr <= '0;
      oEnMul     <= 4'd0;
      oEnAdd     <= 1'b0;
      oEnAcc     <= 1'b0;
      oDone      <= 1'b0;

      if (w_drop) begin
        oOverrun <= 1'b1;
      end else if (iClrOverrun) begin
        oOverrun <= 1'b0;
      end

      case (r_state)
        S_IDLE: begin
          if (iEnSample) begin
            r_state    <= S_RD;
            r_tap      <= 4'd0;
            oBusy      <= 1'b1;
            oCoeffRdEn <= 1'b1;
            oCoeffAddr <= LP_BASE;
          end
        end
        // RD holds r_tap at 0, so it shares the advance path with the MAC taps.
        S_RD, S_MAC: begin
          if (r_state == S_MAC && r_tap == LP_TAPS) begin
            r_state <= S_DONE;
            r_tap   <= 4'd0;
            oDone   <= 1'b1;
          end else begin
            r_state <= S_MAC;
            r_tap   <= w_next_tap;
            oEnMul  <= w_next_tap;
            oEnAdd  <= 1'b1;
            oEnAcc  <= 1'b1;
            if (w_more) begin
              oCoeffRdEn <= 1'b1;
              oCoeffAddr <= LP_BASE + ADDR_WIDTH'(w_next_tap);
            end
          end
        end
        S_DONE: begin
          if (w_restart) begin
            r_state    <= S_RD;
            r_tap      <= 4'd0;
            oCoeffRdEn <= 1'b1;
            oCoeffAddr <= LP_BASE;
          end else begin
            r_state <= S_IDLE;
            oBusy   <= 1'b0;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_tap   <= 4'd0;
          oBusy   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fir_mac_sequencer.sv
// Bench for fir_mac_sequencer: three parameterisations share stimulus and are checked every cycle
// against a schedule-based reference model, plus a vector table and hand-written corner sequences.
module tb_fir_mac_sequencer;

`ifdef SAMPLE_QUEUE_EN
  localparam bit QUEUE = 1'b1;
`else
  localparam bit QUEUE = 1'b0;
`endif

  localparam int NDUT = 3;
  localparam int M_TAPS [NDUT] = '{5, 1, 4};
  localparam int M_BASE [NDUT] = '{0, 15, 14};

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic en_sample = 1'b0;
  logic clr_ovr = 1'b0;

  always #5 clk = ~clk;

  // vector layout: {rd[13], addr[12:9], mul[8:5], add[4], acc[3], busy[2], done[1], ovr[0]}
  logic        rd   [NDUT];
  logic [3:0]  addr [NDUT];
  logic [3:0]  mul  [NDUT];
  logic        add  [NDUT];
  logic        acc  [NDUT];
  logic        busy [NDUT];
  logic        done [NDUT];
  logic        ovr  [NDUT];
  logic [13:0] act  [NDUT];

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    fir_mac_sequencer #(.TAPS(M_TAPS[g]), .ADDR_WIDTH(4), .BASE_ADDR(M_BASE[g])) u_dut (
      .iClk_12M   (clk),
      .iRsn       (rst_n),
      .iEnSample  (en_sample),
      .iClrOverrun(clr_ovr),
      .oCoeffRdEn (rd[g]),
      .oCoeffAddr (addr[g]),
      .oEnMul     (mul[g]),
      .oEnAdd     (add[g]),
      .oEnAcc     (acc[g]),
      .oBusy      (busy[g]),
      .oDone      (done[g]),
      .oOverrun   (ovr[g])
    );
    assign act[g] = {rd[g], addr[g], mul[g], add[g], acc[g], busy[g], done[g], ovr[g]};
  end

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // Reference model: position within the current sample's schedule (-1 = idle).
  int pos  [NDUT];
  bit pend [NDUT];
  bit movr [NDUT];

  function automatic logic [13:0] mk(logic r, logic [3:0] a, logic [3:0] m, logic ad, logic ac,
                                     logic b, logic d, logic o);
    return {r, a, m, ad, ac, b, d, o};
  endfunction

  function automatic logic [13:0] masked(logic [13:0] v);
    logic [13:0] r;
    r = v;
    if (!r[13]) r[12:9] = 4'd0;
    return r;
  endfunction

  function automatic logic [13:0] model_vec(int i);
    int j;
    logic r, ad, ac, b, d;
    logic [3:0] a, m;
    j = pos[i];
    r = 0; a = 0; m = 0; ad = 0; ac = 0; b = 0; d = 0;
    if (j >= 0) b = 1;
    if (j == 0) begin
      r = 1;
      a = 4'(M_BASE[i]);
    end else if (j >= 1 && j <= M_TAPS[i]) begin
      m = 4'(j); ad = 1; ac = 1;
      if (j < M_TAPS[i]) begin
        r = 1;
        a = 4'(M_BASE[i] + j);
      end
    end else if (j == M_TAPS[i] + 1) begin
      d = 1;
    end
    return {r, a, m, ad, ac, b, d, movr[i]};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NDUT; i++) begin
      pos[i] = -1; pend[i] = 0; movr[i] = 0;
    end
  endtask

  task automatic model_edge(bit st, bit clr);
    for (int i = 0; i < NDUT; i++) begin
      bit drop;
      drop = 0;
      if (pos[i] < 0) begin
        if (st) pos[i] = 0;
      end else if (pos[i] == M_TAPS[i] + 1) begin
        if (QUEUE && (pend[i] || st)) begin
          pos[i] = 0;
          drop = pend[i] && st;
        end else begin
          pos[i] = -1;
          drop = st;
        end
        pend[i] = 0;
      end else begin
        pos[i] = pos[i] + 1;
        if (st) begin
          if (QUEUE && !pend[i]) pend[i] = 1;
          else drop = 1;
        end
      end
      if (drop) movr[i] = 1;
      else if (clr) movr[i] = 0;
    end
  endtask

  task automatic check(string name, logic [13:0] got, logic [13:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s cycle %0d: got %b required %b", name, cyc, got, exp);
    end
  endtask

  task automatic check_model();
    for (int i = 0; i < NDUT; i++)
      check($sformatf("model_dut%0d", i), masked(act[i]), masked(model_vec(i)));
  endtask

  // Called at a negedge: drive inputs, let one active edge pass, check at the following negedge.
  task automatic step(bit st, bit clr);
    en_sample = st;
    clr_ovr   = clr;
    @(posedge clk);
    model_edge(st, clr);
    @(negedge clk);
    cyc++;
    en_sample = 0;
    clr_ovr   = 0;
    check_model();
  endtask

  task automatic idle(int n);
    for (int k = 0; k < n; k++) step(0, 0);
  endtask

  typedef struct {
    bit          st;
    bit          clr;
    logic [13:0] exp;
  } vec_t;

  vec_t tbl [8];

  task automatic run_table(string tag);
    for (int k = 0; k < 8; k++) begin
      step(tbl[k].st, tbl[k].clr);
      check($sformatf("%s_tbl%0d", tag, k), masked(act[0]), masked(tbl[k].exp));
    end
  endtask

  task automatic check_all_zero(string name);
    for (int i = 0; i < NDUT; i++) check($sformatf("%s_dut%0d", name, i), act[i], 14'd0);
  endtask

  initial begin
    // TAPS=5, BASE=0: one isolated sample, row k is the cycle after the k-th active edge.
    tbl[0] = '{1'b1, 1'b0, mk(1, 4'd0, 4'd0, 0, 0, 1, 0, 0)};
    tbl[1] = '{1'b0, 1'b0, mk(1, 4'd1, 4'd1, 1, 1, 1, 0, 0)};
    tbl[2] = '{1'b0, 1'b0, mk(1, 4'd2, 4'd2, 1, 1, 1, 0, 0)};
    tbl[3] = '{1'b0, 1'b0, mk(1, 4'd3, 4'd3, 1, 1, 1, 0, 0)};
    tbl[4] = '{1'b0, 1'b0, mk(1, 4'd4, 4'd4, 1, 1, 1, 0, 0)};
    tbl[5] = '{1'b0, 1'b0, mk(0, 4'd0, 4'd5, 1, 1, 1, 0, 0)};
    tbl[6] = '{1'b0, 1'b0, mk(0, 4'd0, 4'd0, 0, 0, 1, 1, 0)};
    tbl[7] = '{1'b0, 1'b0, mk(0, 4'd0, 4'd0, 0, 0, 0, 0, 0)};

    model_reset();
    rst_n = 0;
    repeat (2) @(negedge clk);
    check_all_zero("reset");
    rst_n = 1;
    idle(3);

    run_table("first");

    // Collision 4 cycles after a strobe: dropped without queue, held pending with it.
    step(1, 0);
    idle(3);
    step(1, 0);
    check("collide_ovr", {13'd0, ovr[0]}, {13'd0, !QUEUE});
    idle(16);
    step(0, 1);
    check("clr_ovr", {13'd0, ovr[0]}, 14'd0);

    // Drop and clear in the same cycle: set wins.
    step(1, 0);
    idle(1);
    step(1, 0);
    step(1, 1);
    check("set_wins", {13'd0, ovr[0]}, 14'd1);
    idle(16);
    step(0, 1);
    check("clr_after_set", {13'd0, ovr[0]}, 14'd0);

    // Strobe exactly at DONE (7 cycles after the first).
    step(1, 0);
    idle(6);
    step(1, 0);
    check("done_strobe_busy", {13'd0, busy[0]}, {13'd0, QUEUE});
    check("done_strobe_ovr", {13'd0, ovr[0]}, {13'd0, !QUEUE});
    idle(16);
    step(0, 1);

    // TAPS=1, BASE=15: RD, one tap with no further read, DONE.
    step(1, 0);
    check("t1_rd", masked(act[1]), mk(1, 4'd15, 4'd0, 0, 0, 1, 0, 0));
    step(0, 0);
    check("t1_mac", masked(act[1]), mk(0, 4'd0, 4'd1, 1, 1, 1, 0, 0));
    step(0, 0);
    check("t1_done", masked(act[1]), mk(0, 4'd0, 4'd0, 0, 0, 1, 1, 0));
    idle(10);

    // Asynchronous reset mid-sequence.
    step(1, 0);
    idle(2);
    #2 rst_n = 0;
    #1 check_all_zero("async_rst");
    model_reset();
    @(posedge clk);
    @(negedge clk);
    check_all_zero("rst_hold");
    rst_n = 1;
    idle(2);
    run_table("after_rst");

    for (int k = 0; k < 600; k++)
      step($urandom_range(0, 3) == 0, $urandom_range(0, 15) == 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
